// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative 32-bit signed multiply / divide unit with HI/LO result registers.
//   A multiply uses radix-2 Booth recoding, one step per cycle. A divide uses
//   restoring division on the operand magnitudes, one quotient bit per cycle,
//   followed by a sign fix-up. Either operation takes 32 cycles in its working
//   state, then spends one cycle in DONE. A divide by zero goes straight to
//   DONE, sets div_zero, and leaves HI/LO untouched.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous active-low reset
//   start     request pulse, accepted only in IDLE
//   op        0 = signed multiply, 1 = signed divide
//   a, b      multiplicand/dividend, multiplier/divisor (32 bits each)
//   busy      high in MULT or DIV
//   done      one-cycle pulse in DONE
//   div_zero  last accepted divide had b = 0, held until the next accepted start
//   hi, lo    result registers (product[63:32]/[31:0], or remainder/quotient)
//
// State | Meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; operands are latched when start is accepted
// MULT  | one Booth step per cycle, 32 cycles
// DIV   | one restoring-division step per cycle, 32 cycles
// DONE  | single cycle, done = 1, then return to IDLE
// -----------------------------------------------------------------------------
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    // Multiply: sign-extended multiplicand. Divide: divisor magnitude.
    logic [32:0] m_q, m_d;
    // Multiply: Booth A register (33 bits so that subtracting -2^31 cannot overflow).
    // Divide: partial remainder.
    logic [32:0] acc_hi_q, acc_hi_d;
    // Multiply: multiplier being shifted out. Divide: dividend shifting out / quotient shifting in.
    logic [31:0] acc_lo_q, acc_lo_d;
    logic        qm1_q, qm1_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        div_zero_q, div_zero_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Datapath step results
    logic [32:0] booth_sum;
    logic [32:0] booth_hi;
    logic [31:0] booth_lo;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [32:0] div_rem;
    logic [31:0] div_quo;
    logic [31:0] quo_signed;
    logic [31:0] rem_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        last_iter;

    // -------------------------------------------------------------------------
    // Datapath: one Booth step and one restoring-division step, both computed
    // from the current registers; the FSM picks whichever applies.
    // -------------------------------------------------------------------------
    always_comb begin
        booth_sum  = acc_hi_q;
        booth_hi   = '0;
        booth_lo   = '0;
        div_shift  = '0;
        div_ge     = 1'b0;
        div_rem    = '0;
        div_quo    = '0;
        quo_signed = '0;
        rem_signed = '0;
        a_mag      = '0;
        b_mag      = '0;

        unique case ({acc_lo_q[0], qm1_q})
            2'b01:   booth_sum = acc_hi_q + m_q;
            2'b10:   booth_sum = acc_hi_q - m_q;
            default: booth_sum = acc_hi_q;
        endcase
        // Arithmetic shift right of {A, Q, q-1}.
        booth_hi = {booth_sum[32], booth_sum[32:1]};
        booth_lo = {booth_sum[0], acc_lo_q[31:1]};

        // Shift the next dividend bit into the partial remainder, then try to
        // subtract the divisor; keep the shifted value if it would go negative.
        div_shift = {acc_hi_q[31:0], acc_lo_q[31]};
        div_ge    = (div_shift >= m_q);
        div_rem   = div_ge ? (div_shift - m_q) : div_shift;
        div_quo   = {acc_lo_q[30:0], div_ge};

        quo_signed = q_neg_q ? (32'd0 - div_quo) : div_quo;
        rem_signed = r_neg_q ? (32'd0 - div_rem[31:0]) : div_rem[31:0];

        // |-2^31| is 0x80000000, which is still correct read as unsigned.
        a_mag = a[31] ? (32'd0 - a) : a;
        b_mag = b[31] ? (32'd0 - b) : b;
    end

    assign last_iter = (cnt_q == 6'd31);

    // -------------------------------------------------------------------------
    // Next-state and register updates
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        m_d        = m_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        qm1_d      = qm1_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d      = 6'd0;
                    div_zero_d = 1'b0;
                    acc_hi_d   = '0;
                    qm1_d      = 1'b0;
                    if (!op) begin
                        m_d      = {a[31], a};
                        acc_lo_d = b;
                        q_neg_d  = 1'b0;
                        r_neg_d  = 1'b0;
                        state_d  = MULT;
                    end else if (b == 32'd0) begin
                        // Nothing to iterate; report and finish next cycle.
                        div_zero_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        m_d      = {1'b0, b_mag};
                        acc_lo_d = a_mag;
                        q_neg_d  = a[31] ^ b[31];
                        r_neg_d  = a[31];
                        state_d  = DIV;
                    end
                end
            end

            MULT: begin
                acc_hi_d = booth_hi;
                acc_lo_d = booth_lo;
                qm1_d    = acc_lo_q[0];
                cnt_d    = cnt_q + 6'd1;
                if (last_iter) begin
                    cnt_d   = 6'd0;
                    // booth_hi[32] is only sign extension of the 64-bit product.
                    hi_d    = booth_hi[31:0];
                    lo_d    = booth_lo;
                    state_d = DONE;
                end
            end

            DIV: begin
                acc_hi_d = div_rem;
                acc_lo_d = div_quo;
                cnt_d    = cnt_q + 6'd1;
                if (last_iter) begin
                    cnt_d   = 6'd0;
                    hi_d    = rem_signed;
                    lo_d    = quo_signed;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            m_q        <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            qm1_q      <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            m_q        <= m_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            qm1_q      <= qm1_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = (state_q == MULT) || (state_q == DIV);
    assign done     = (state_q == DONE);
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports named clk and reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port reset, input, 1 bit: synchronous, active-low reset; sampled only on the clk rising edge.
REQ-004 Port start, input, 1 bit: request pulse; accepted only in IDLE.
REQ-005 Port op, input, 1 bit: operation select; 0 = signed multiply, 1 = signed divide.
REQ-006 Port a, input, 32 bits: multiplicand or dividend.
REQ-007 Port b, input, 32 bits: multiplier or divisor.
REQ-008 Port busy, output, 1 bit: high while an operation is in progress.
REQ-009 Port done, output, 1 bit: one-cycle completion pulse.
REQ-010 Port div_zero, output, 1 bit: last accepted divide had b = 0.
REQ-011 Port hi, output, 32 bits: HI register; feeds the register write-data select for mfhi.
REQ-012 Port lo, output, 32 bits: LO register; feeds the register write-data select for mflo.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, MULT, DIV and DONE.
REQ-014 In IDLE with start=1 at edge N, the block SHALL latch a, b and op internally; later changes to a, b or op SHALL have no effect.
REQ-015 On acceptance, the block SHALL clear div_zero and zero its 6-bit iteration counter.
REQ-016 The transition from IDLE SHALL be: op=0 -> MULT; op=1 with b != 0 -> DIV; op=1 with b = 0 -> DONE.
REQ-017 MULT SHALL implement radix-2 Booth signed multiplication, one iteration per cycle, 32 iterations, producing a 64-bit product.
REQ-018 DIV SHALL implement restoring division on operand magnitudes, one quotient bit per cycle, 32 iterations.
REQ-019 DIV SHALL negate the quotient when the operand signs differ, and SHALL give the remainder the sign of the dividend.
REQ-020 After the 32nd iteration the FSM SHALL enter DONE; the counter SHALL wrap from 31 to 0 on that transition.
REQ-021 The DONE state SHALL last one cycle, assert done=1 for that cycle, then return to IDLE.
REQ-022 For mult, hi and lo SHALL update on the edge entering DONE, with hi = product[63:32] and lo = product[31:0].
REQ-023 For div with b != 0, hi and lo SHALL update on the edge entering DONE, with lo = quotient and hi = remainder.
REQ-024 For a normal operation accepted at edge N, busy SHALL be 1 in cycles N+1..N+32 and done SHALL be 1 in cycle N+33.
REQ-025 For a divide by zero accepted at edge N, done=1 and div_zero=1 SHALL hold in cycle N+1, and hi and lo SHALL remain unchanged.
REQ-026 div_zero SHALL hold its value until the next accepted start.
REQ-027 start SHALL be ignored while busy=1 or in DONE, with no queuing and no effect on results.
REQ-028 The block SHALL accept a new start in the IDLE cycle immediately following DONE, so back-to-back issue is one start every 34 cycles.
REQ-029 The overflow case a=0x80000000, b=0xFFFFFFFF divide SHALL yield lo=0x80000000 and hi=0x00000000 (truncated result, no flag).
REQ-030 hi and lo SHALL change only on DONE entry or on reset.

Reset
REQ-031 With reset=0 at a rising edge, the block SHALL enter IDLE with busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0 and internal operands cleared.
REQ-032 Reset SHALL take priority over all other activity, including mid-MULT, mid-DIV and during DONE.
REQ-033 An operation in progress when reset is asserted SHALL be abandoned; no done pulse and no hi/lo update SHALL follow it.
REQ-034 start SHALL be ignored in any cycle where reset=0.

Verification
REQ-035 Mult a=7, b=0xFFFFFFFD -> done in cycle N+33 with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-036 Mult a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-037 Div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then div a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=0x00000001.
REQ-038 Preload hi/lo by mult 3*5, then div a=9, b=0 -> done and div_zero in cycle N+1, hi=0, lo=15 unchanged; div_zero stays 1 until the next start.
REQ-039 Start mult, pulse start with other operands at cycle N+10 -> ignored; original result delivered at N+33.
REQ-040 Start div, assert reset=0 at cycle N+15 -> next cycle IDLE with all outputs 0 and no done pulse; a fresh mult 2*3 then gives lo=6.
